neighbor_table_param: RTL and testbench

NEIGHBOR_TABLE_PARAM -- requirements
Module: neighbor_table_param

---
 rtl/neighbor_table_param_if.sv | 50 +++++
 rtl/neighbor_table_param.sv | 254 +++++++++++++++++++++++++
 tb/tb_neighbor_table_param.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_table_param_if.sv
// Neighbor-table port bundle: write/age/heartbeat strobes, read port and best-hop search results.
// Pure wiring; the master drives requests, the slave (the table) drives lookup and search results.
interface neighbor_table_param_if #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 8
);
    localparam int IW = $clog2(DEPTH);

    logic                  wr_en;
    logic                  hb_reset;
    logic                  age_tick;
    logic [WORD_WIDTH-1:0] fNodeID;
    logic [WORD_WIDTH-1:0] fNodeHops;
    logic [WORD_WIDTH-1:0] fNodeQValue;
    logic [WORD_WIDTH-1:0] fNodeEnergy;
    logic [WORD_WIDTH-1:0] fNodeCHHops;
    logic                  search_start;
    logic [IW-1:0]         rd_index;

    logic [WORD_WIDTH-1:0] mNodeID;
    logic [WORD_WIDTH-1:0] mNodeHops;
    logic [WORD_WIDTH-1:0] mNodeQValue;
    logic [WORD_WIDTH-1:0] mNodeEnergy;
    logic [WORD_WIDTH-1:0] mNodeCHHops;
    logic [IW:0]           neighborCount;
    logic                  table_full;
    logic                  wr_drop;
    logic                  search_busy;
    logic                  search_done;
    logic                  best_valid;
    logic [IW-1:0]         bestIndex;
    logic [WORD_WIDTH-1:0] bestNodeID;
    logic [WORD_WIDTH-1:0] bestQValue;

    modport master (
        output wr_en, hb_reset, age_tick, fNodeID, fNodeHops, fNodeQValue,
               fNodeEnergy, fNodeCHHops, search_start, rd_index,
        input  mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops,
               neighborCount, table_full, wr_drop, search_busy, search_done,
               best_valid, bestIndex, bestNodeID, bestQValue
    );

    modport slave (
        input  wr_en, hb_reset, age_tick, fNodeID, fNodeHops, fNodeQValue,
               fNodeEnergy, fNodeCHHops, search_start, rd_index,
        output mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops,
               neighborCount, table_full, wr_drop, search_busy, search_done,
               best_valid, bestIndex, bestNodeID, bestQValue
    );
endinterface

// File: rtl/neighbor_table_param.sv
// Aging neighbor table with ID-keyed insert/refresh and a sequential best-QValue search.
// Writes/aging take effect in 1 cycle; search takes DEPTH+1 cycles; full-table inserts are dropped (wr_drop).
module neighbor_table_param #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AGE_MAX    = 3
) (
    input logic                    clk,
    input logic                    nrst,
    neighbor_table_param_if.slave  bus
);
    localparam int IW      = $clog2(DEPTH);
    localparam int AW      = $clog2(AGE_MAX + 1);
    localparam int RD_SPAN = 1 << IW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] qv;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] chhops;
    } node_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    age_q [DEPTH];
    logic [AW-1:0]    age_d [DEPTH];
    node_t            node_q [DEPTH];
    node_t            node_d [DEPTH];
    logic [IW:0]      count_q, count_d;
    logic             wr_drop_q, wr_drop_d;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         scan_idx_q, scan_idx_d;
    logic                  cand_vld_q, cand_vld_d;
    logic [IW-1:0]         cand_idx_q, cand_idx_d;
    logic [WORD_WIDTH-1:0] cand_id_q, cand_id_d;
    logic [WORD_WIDTH-1:0] cand_qv_q, cand_qv_d;
    logic [WORD_WIDTH-1:0] cand_hops_q, cand_hops_d;
    logic                  best_vld_q, best_vld_d;
    logic [IW-1:0]         best_idx_q, best_idx_d;
    logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
    logic [WORD_WIDTH-1:0] best_qv_q, best_qv_d;

    node_t         wr_node;
    logic          match_hit, free_hit, wr_ok;
    logic [IW-1:0] match_idx, free_idx, wr_idx;

    assign wr_node = {bus.fNodeID, bus.fNodeHops, bus.fNodeQValue,
                      bus.fNodeEnergy, bus.fNodeCHHops};

    // Descending loop so the lowest matching / free index wins.
    always_comb begin
        match_hit = 1'b0;
        free_hit  = 1'b0;
        match_idx = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (node_q[i].id == bus.fNodeID)) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign wr_ok  = match_hit | free_hit;
    assign wr_idx = match_hit ? match_idx : free_idx;

    always_comb begin
        valid_d   = valid_q;
        wr_drop_d = 1'b0;
        count_d   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i]  = age_q[i];
            node_d[i] = node_q[i];
        end
        if (bus.hb_reset) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
        end else begin
            if (bus.age_tick) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i]) begin
                        if (age_q[i] == AW'(AGE_MAX - 1)) begin
                            valid_d[i] = 1'b0;
                            age_d[i]   = '0;
                        end else begin
                            age_d[i] = age_q[i] + 1'b1;
                        end
                    end
                end
            end
            // Applied after aging so the written entry always ends fresh and valid.
            if (bus.wr_en) begin
                if (wr_ok) begin
                    valid_d[wr_idx] = 1'b1;
                    age_d[wr_idx]   = '0;
                    node_d[wr_idx]  = wr_node;
                end else begin
                    wr_drop_d = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) count_d = count_d + (IW + 1)'(valid_d[i]);
    end

    // Read port padded to a power of two so out-of-range indices return zero.
    node_t rd_tab [RD_SPAN];
    node_t rd_node;

    for (genvar g = 0; g < RD_SPAN; g++) begin : g_rd
        if (g < DEPTH) begin : g_live
            assign rd_tab[g] = valid_q[g] ? node_q[g] : '0;
        end else begin : g_pad
            assign rd_tab[g] = '0;
        end
    end

    assign rd_node = rd_tab[bus.rd_index];

    node_t scan_node;
    logic  scan_vld, scan_take;
    logic                  nxt_vld;
    logic [IW-1:0]         nxt_idx;
    logic [WORD_WIDTH-1:0] nxt_id, nxt_qv, nxt_hops;

    assign scan_node = node_q[scan_idx_q];
    assign scan_vld  = valid_q[scan_idx_q];
    // Strict comparisons keep the earlier index on a full tie.
    assign scan_take = scan_vld &&
                       (!cand_vld_q || (scan_node.qv > cand_qv_q) ||
                        ((scan_node.qv == cand_qv_q) && (scan_node.hops < cand_hops_q)));

    assign nxt_vld  = scan_take ? 1'b1           : cand_vld_q;
    assign nxt_idx  = scan_take ? scan_idx_q     : cand_idx_q;
    assign nxt_id   = scan_take ? scan_node.id   : cand_id_q;
    assign nxt_qv   = scan_take ? scan_node.qv   : cand_qv_q;
    assign nxt_hops = scan_take ? scan_node.hops : cand_hops_q;

    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        cand_vld_d  = cand_vld_q;
        cand_idx_d  = cand_idx_q;
        cand_id_d   = cand_id_q;
        cand_qv_d   = cand_qv_q;
        cand_hops_d = cand_hops_q;
        best_vld_d  = best_vld_q;
        best_idx_d  = best_idx_q;
        best_id_d   = best_id_q;
        best_qv_d   = best_qv_q;
        if (bus.hb_reset) begin
            state_d    = ST_IDLE;
            scan_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.search_start) begin
                        state_d     = ST_SCAN;
                        scan_idx_d  = '0;
                        cand_vld_d  = 1'b0;
                        cand_idx_d  = '0;
                        cand_id_d   = '0;
                        cand_qv_d   = '0;
                        cand_hops_d = '0;
                    end
                end
                ST_SCAN: begin
                    cand_vld_d  = nxt_vld;
                    cand_idx_d  = nxt_idx;
                    cand_id_d   = nxt_id;
                    cand_qv_d   = nxt_qv;
                    cand_hops_d = nxt_hops;
                    if (scan_idx_q == IW'(DEPTH - 1)) begin
                        state_d    = ST_DONE;
                        best_vld_d = nxt_vld;
                        best_idx_d = nxt_idx;
                        best_id_d  = nxt_id;
                        best_qv_d  = nxt_qv;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_q     <= '0;
            count_q     <= '0;
            wr_drop_q   <= 1'b0;
            state_q     <= ST_IDLE;
            scan_idx_q  <= '0;
            cand_vld_q  <= 1'b0;
            cand_idx_q  <= '0;
            cand_id_q   <= '0;
            cand_qv_q   <= '0;
            cand_hops_q <= '0;
            best_vld_q  <= 1'b0;
            best_idx_q  <= '0;
            best_id_q   <= '0;
            best_qv_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i]  <= '0;
                node_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            wr_drop_q   <= wr_drop_d;
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            cand_vld_q  <= cand_vld_d;
            cand_idx_q  <= cand_idx_d;
            cand_id_q   <= cand_id_d;
            cand_qv_q   <= cand_qv_d;
            cand_hops_q <= cand_hops_d;
            best_vld_q  <= best_vld_d;
            best_idx_q  <= best_idx_d;
            best_id_q   <= best_id_d;
            best_qv_q   <= best_qv_d;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i]  <= age_d[i];
                node_q[i] <= node_d[i];
            end
        end
    end

    assign bus.mNodeID       = rd_node.id;
    assign bus.mNodeHops     = rd_node.hops;
    assign bus.mNodeQValue   = rd_node.qv;
    assign bus.mNodeEnergy   = rd_node.energy;
    assign bus.mNodeCHHops   = rd_node.chhops;
    assign bus.neighborCount = count_q;
    assign bus.table_full    = (count_q == (IW + 1)'(DEPTH));
    assign bus.wr_drop       = wr_drop_q;
    assign bus.search_busy   = (state_q != ST_IDLE);
    assign bus.search_done   = (state_q == ST_DONE);
    assign bus.best_valid    = best_vld_q;
    assign bus.bestIndex     = best_idx_q;
    assign bus.bestNodeID    = best_id_q;
    assign bus.bestQValue    = best_qv_q;

endmodule

// File: tb/tb_neighbor_table_param.sv
// Directed bench for neighbor_table_param: vector table for insert/refresh/aging, hand sequences for full table and search.
module tb_neighbor_table_param;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    neighbor_table_param_if #(.WORD_WIDTH(W), .DEPTH(DEPTH)) bus ();

    neighbor_table_param #(.WORD_WIDTH(W), .DEPTH(DEPTH), .AGE_MAX(3)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        logic         wr;
        logic         age;
        logic         hb;
        logic [W-1:0] id;
        logic [W-1:0] hops;
        logic [W-1:0] qv;
        logic [2:0]   rd;
        logic [3:0]   cnt;
        logic [W-1:0] mid;
        logic [W-1:0] mqv;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr_en        = 1'b0;
        bus.hb_reset     = 1'b0;
        bus.age_tick     = 1'b0;
        bus.search_start = 1'b0;
    endtask

    task automatic write_node(input logic [W-1:0] id, input logic [W-1:0] hops, input logic [W-1:0] qv);
        bus.wr_en       = 1'b1;
        bus.fNodeID     = id;
        bus.fNodeHops   = hops;
        bus.fNodeQValue = qv;
        bus.fNodeEnergy = id + 16'd100;
        bus.fNodeCHHops = id + 16'd200;
        edge_step();
        bus.wr_en = 1'b0;
    endtask

    task automatic heartbeat();
        bus.hb_reset = 1'b1;
        edge_step();
        bus.hb_reset = 1'b0;
    endtask

    // Returns edges after the start edge until search_done is seen (-1 if never); optional start poke mid-scan.
    task automatic run_search(input bit poke, output int lat);
        lat = -1;
        bus.search_start = 1'b1;
        edge_step();
        bus.search_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (poke && k == 3) bus.search_start = 1'b1;
            edge_step();
            bus.search_start = 1'b0;
            if (bus.search_done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  seen_done;

        //           wr age hb  id  hops qv rd cnt mid mqv
        vecs[0]  = '{1, 0, 0,  5, 1, 4, 0, 1,  5, 4};
        vecs[1]  = '{1, 0, 0,  6, 3, 2, 1, 2,  6, 2};
        vecs[2]  = '{1, 0, 0,  7, 2, 1, 2, 3,  7, 1};
        vecs[3]  = '{1, 0, 0,  6, 3, 9, 1, 3,  6, 9};
        vecs[4]  = '{0, 0, 0,  0, 0, 0, 3, 3,  0, 0};
        vecs[5]  = '{0, 1, 0,  0, 0, 0, 0, 3,  5, 4};
        vecs[6]  = '{1, 1, 0,  5, 1, 4, 0, 3,  5, 4};
        vecs[7]  = '{0, 1, 0,  0, 0, 0, 1, 1,  0, 0};
        vecs[8]  = '{1, 0, 0,  8, 1, 5, 1, 2,  8, 5};
        vecs[9]  = '{1, 1, 0,  9, 2, 6, 2, 3,  9, 6};
        vecs[10] = '{1, 1, 0, 12, 1, 7, 3, 3, 12, 7};
        vecs[11] = '{0, 0, 0,  0, 0, 0, 0, 3,  0, 0};
        vecs[12] = '{1, 1, 1, 10, 1, 1, 0, 0,  0, 0};
        vecs[13] = '{1, 0, 0, 11, 2, 3, 0, 1, 11, 3};

        clear_inputs();
        bus.fNodeID = '0; bus.fNodeHops = '0; bus.fNodeQValue = '0;
        bus.fNodeEnergy = '0; bus.fNodeCHHops = '0; bus.rd_index = '0;
        #12;
        check("rst_count", bus.neighborCount, 0);
        check("rst_full", bus.table_full, 0);
        check("rst_drop", bus.wr_drop, 0);
        check("rst_busy", bus.search_busy, 0);
        check("rst_done", bus.search_done, 0);
        check("rst_best_valid", bus.best_valid, 0);
        check("rst_mid", bus.mNodeID, 0);
        #1 nrst = 1'b1;
        edge_step();

        for (int i = 0; i < 14; i++) begin
            bus.wr_en       = vecs[i].wr;
            bus.age_tick    = vecs[i].age;
            bus.hb_reset    = vecs[i].hb;
            bus.fNodeID     = vecs[i].id;
            bus.fNodeHops   = vecs[i].hops;
            bus.fNodeQValue = vecs[i].qv;
            bus.fNodeEnergy = vecs[i].id + 16'd100;
            bus.fNodeCHHops = vecs[i].id + 16'd200;
            bus.rd_index    = vecs[i].rd;
            edge_step();
            clear_inputs();
            check($sformatf("vec%0d_count", i), bus.neighborCount, vecs[i].cnt);
            check($sformatf("vec%0d_mid", i), bus.mNodeID, vecs[i].mid);
            check($sformatf("vec%0d_mqv", i), bus.mNodeQValue, vecs[i].mqv);
            if (vecs[i].mid != 0) begin
                check($sformatf("vec%0d_menergy", i), bus.mNodeEnergy, vecs[i].mid + 100);
                check($sformatf("vec%0d_mchhops", i), bus.mNodeCHHops, vecs[i].mid + 200);
            end
        end

        // Full table and dropped insert
        heartbeat();
        for (int i = 0; i < DEPTH; i++) write_node(16'(20 + i), 16'd1, 16'(i));
        check("fill_count", bus.neighborCount, 8);
        check("fill_full", bus.table_full, 1);
        write_node(16'd99, 16'd1, 16'd1);
        check("drop_pulse", bus.wr_drop, 1);
        check("drop_count", bus.neighborCount, 8);
        edge_step();
        check("drop_clear", bus.wr_drop, 0);
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_index = 3'(i);
            #1;
            check($sformatf("full_slot%0d_id", i), bus.mNodeID, 20 + i);
        end
        write_node(16'd22, 16'd4, 16'd50);
        check("full_refresh_drop", bus.wr_drop, 0);
        bus.rd_index = 3'd2;
        #1;
        check("full_refresh_qv", bus.mNodeQValue, 50);

        // Best-hop search with a QValue tie broken by hops; a start during the scan is ignored
        heartbeat();
        write_node(16'd30, 16'd1, 16'd4);
        write_node(16'd31, 16'd3, 16'd9);
        write_node(16'd32, 16'd2, 16'd9);
        write_node(16'd33, 16'd1, 16'd2);
        run_search(1'b1, lat);
        check("search_latency", lat, DEPTH);
        check("search_busy_done", bus.search_busy, 1);
        check("best_valid", bus.best_valid, 1);
        check("best_index", bus.bestIndex, 2);
        check("best_id", bus.bestNodeID, 32);
        check("best_qv", bus.bestQValue, 9);
        edge_step();
        check("search_idle_busy", bus.search_busy, 0);
        check("search_idle_done", bus.search_done, 0);
        check("best_hold_index", bus.bestIndex, 2);

        // Heartbeat aborts a scan in progress; previous best is retained
        write_node(16'd40, 16'd1, 16'd20);
        bus.search_start = 1'b1;
        edge_step();
        bus.search_start = 1'b0;
        for (int k = 0; k < 3; k++) edge_step();
        check("abort_busy_before", bus.search_busy, 1);
        heartbeat();
        check("abort_count", bus.neighborCount, 0);
        check("abort_busy", bus.search_busy, 0);
        check("abort_done", bus.search_done, 0);
        seen_done = 1'b0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            edge_step();
            if (bus.search_done) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_best_valid", bus.best_valid, 1);
        check("abort_best_index", bus.bestIndex, 2);
        check("abort_best_qv", bus.bestQValue, 9);

        // Empty-table search clears the best outputs
        run_search(1'b0, lat);
        check("empty_latency", lat, DEPTH);
        check("empty_best_valid", bus.best_valid, 0);
        check("empty_best_index", bus.bestIndex, 0);
        check("empty_best_id", bus.bestNodeID, 0);
        check("empty_best_qv", bus.bestQValue, 0);

        // Asynchronous reset in the middle of a scan
        write_node(16'd50, 16'd1, 16'd7);
        run_search(1'b0, lat);
        check("pre_rst_best_qv", bus.bestQValue, 7);
        bus.search_start = 1'b1;
        edge_step();
        bus.search_start = 1'b0;
        for (int k = 0; k < 3; k++) edge_step();
        bus.rd_index = 3'd0;
        #2 nrst = 1'b0;
        #1;
        check("arst_count", bus.neighborCount, 0);
        check("arst_busy", bus.search_busy, 0);
        check("arst_done", bus.search_done, 0);
        check("arst_best_valid", bus.best_valid, 0);
        check("arst_best_id", bus.bestNodeID, 0);
        check("arst_best_qv", bus.bestQValue, 0);
        check("arst_mid", bus.mNodeID, 0);
        #10 nrst = 1'b1;
        edge_step();
        check("post_rst_count", bus.neighborCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
